// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline memory stage.
// State encoding, timeout default and access qualification.
package wisc_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int TIMEOUT_DEF = 255;

  function automatic logic is_access(
    input logic v,
    input logic rd,
    input logic wr,
    input logic a0,
    input logic e
  );
    return v & (rd ^ wr) & ~a0 & ~e;
  endfunction

endpackage

// File: rtl/dff_16bit.sv
// 16-bit register with write enable.
// Synchronous active-low reset.
module dff_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)
      q <= '0;
    else if (wen)
      q <= d;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores, stalls on misses,
// times out stuck accesses and latches a sticky error flag.
module mem_stage
  import wisc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_busy,
  output logic        stall,
  output logic [15:0] read_data,
  output logic        err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [1:0] state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       err_nx;
  logic       cap;
  logic       access;
  logic       bad;
  logic       hit;

  assign mem_addr  = addr;
  assign mem_wdata = wdata;

  assign access = is_access(req_valid, mem_read, mem_write,
                            addr[0], err);
  assign bad = req_valid & ~err
             & ((mem_read & mem_write)
             | ((mem_read ^ mem_write) & addr[0]));
  assign hit = access & ~mem_busy & mem_done;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err;
    cap      = 1'b0;
    mem_en   = 1'b0;
    mem_wr   = 1'b0;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        mem_en = access;
        mem_wr = access & mem_write;
        stall  = access & ~hit;
        cap    = hit & mem_read;
        if (bad)
          err_nx = 1'b1;
        if (access & ~mem_busy & ~mem_done) begin
          state_nx = WAIT;
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_nx = cnt + 8'd1;
        if (mem_done) begin
          cap      = mem_read;
          state_nx = DONE;
        end else if (cnt + 8'd1 == TMO) begin
          // give up: release the pipeline and poison the stage
          err_nx   = 1'b1;
          stall    = 1'b0;
          state_nx = IDLE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      mem_en = 1'b0;
      mem_wr = 1'b0;
      stall  = 1'b0;
      cap    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end
  end

  dff_16bit u_rd (
    .clk (clk),
    .rst (rst),
    .wen (cap),
    .d   (mem_rdata),
    .q   (read_data)
  );

endmodule
